// File: rtl/fetch_pkg.sv
// Shared pipeline bundle types for the fetch/decode boundary.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] fetched_inst;
    } if_id_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the IF_ID register, one outstanding request.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output if_id_t      if_id_reg,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state_q;
    state_t      redir_nxt;
    logic [31:0] pc_q;
    logic [31:0] hold_q;
    logic [31:0] redir_tgt;
    logic [31:0] load_word;
    logic        grant;
    logic        load_en;
    logic        unused_rpc_lo;

    assign grant         = imem_req & imem_ready;
    assign redir_tgt     = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_lo = ^redirect_pc[1:0];
    assign imem_addr     = pc_q;

    assign load_en = !redirect_en && !stall &&
                     ((state_q == S_WAIT && imem_rvalid) ||
                      state_q == S_HOLD);
    assign load_word = (state_q == S_HOLD) ? hold_q : imem_rdata;

    // A grant or response already in flight must be swallowed via S_DROP.
    always_comb begin
        redir_nxt = S_REQ;
        unique case (state_q)
            S_REQ:  redir_nxt = grant ? S_DROP : S_REQ;
            S_WAIT: redir_nxt = imem_rvalid ? S_REQ : S_DROP;
            S_HOLD: redir_nxt = S_REQ;
            S_DROP: redir_nxt = imem_rvalid ? S_REQ : S_DROP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q                <= S_REQ;
            pc_q                   <= RESET_PC;
            hold_q                 <= '0;
            imem_req               <= 1'b0;
            if_id_reg.pc           <= '0;
            if_id_reg.fetched_inst <= NOP_INST;
            if_id_valid            <= 1'b0;
        end else if (redirect_en) begin
            pc_q                   <= redir_tgt;
            state_q                <= redir_nxt;
            imem_req               <= (redir_nxt == S_REQ);
            if_id_reg.fetched_inst <= NOP_INST;
            if_id_valid            <= 1'b0;
        end else begin
            if (load_en) begin
                if_id_reg.pc           <= pc_q;
                if_id_reg.fetched_inst <= load_word;
                if_id_valid            <= 1'b1;
                pc_q                   <= pc_q + 32'd4;
            end else if (!stall) begin
                if_id_reg.fetched_inst <= NOP_INST;
                if_id_valid            <= 1'b0;
            end

            unique case (state_q)
                S_REQ: begin
                    if (grant) begin
                        state_q  <= S_WAIT;
                        imem_req <= 1'b0;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            hold_q  <= imem_rdata;
                            state_q <= S_HOLD;
                        end else begin
                            state_q  <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        state_q  <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_q  <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else if (load_en) begin
            perf_fetched <= perf_fetched + 32'd1;
        end else if (!stall) begin
            perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

    // Responses are only legal while a request is outstanding.
    a_rvalid_proto: assert property (
        @(posedge clk) disable iff (!reset_n)
        imem_rvalid |-> (state_q == S_WAIT || state_q == S_DROP)
    );

endmodule
